ship_board: RTL



---
 rtl/ship_board.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ship_board.sv
// ship_board: the player's 10x10 ship-occupancy board.
// Places single-cell ships under a no-touch rule by scanning the 3x3 window
// around the target, resolves opponent shots against the board, keeps the
// placed/sunk counts, and serves registered cell reads to the renderer.
module ship_board #(
    parameter int MAX_SHIPS = 10,
    parameter int GRID      = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pick_ship,
    input  logic [7:0] mouse_position,
    input  logic       shot_req,
    input  logic [7:0] shot_pos,
    input  logic [7:0] rd_pos,
    output logic [3:0] ship_count,
    output logic       place_done,
    output logic       place_ok,
    output logic       busy,
    output logic       shot_done,
    output logic       shot_hit,
    output logic       rd_occ,
    output logic       rd_hit,
    output logic       all_sunk
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2,
        DONE   = 2'd3
    } state_e;

    // One row register per grid row, one bit per column.
    typedef logic [GRID-1:0][GRID-1:0] board_t;

    localparam logic [3:0] GRID_L  = 4'(GRID);
    localparam logic [3:0] MAX_CNT = 4'(MAX_SHIPS);
    localparam logic [3:0] IDX_END = 4'd8;

    // True when (r,c) lies on the board.
    function automatic logic in_grid(input logic [3:0] r, input logic [3:0] c);
        return (r < GRID_L) && (c < GRID_L);
    endfunction

    // Bit (r,c) of a board; cells off the board read as 0.
    function automatic logic cell_at(input board_t b, input logic [3:0] r,
                                     input logic [3:0] c);
        logic v;
        v = 1'b0;
        for (int i = 0; i < GRID; i++) begin
            for (int j = 0; j < GRID; j++) begin
                if (r == 4'(i) && c == 4'(j)) begin
                    v = b[i][j];
                end
            end
        end
        return v;
    endfunction

    // Placement state
    state_e     state_q;
    logic [3:0] row_q;
    logic [3:0] col_q;
    logic [3:0] idx_q;
    logic       pick_prev_q;
    logic [3:0] ship_count_q;
    logic       busy_q;
    logic       place_done_q;
    logic       place_ok_q;
    board_t     occ_q;

    // Shot / read state
    board_t     hit_q,       hit_d;
    logic [3:0] sunk_q,      sunk_d;
    logic       shot_done_q, shot_done_d;
    logic       shot_hit_q,  shot_hit_d;
    logic       rd_occ_q,    rd_occ_d;
    logic       rd_hit_q,    rd_hit_d;

    // Request decode and scan-window neighbour lookup
    logic       pick_edge;
    logic [3:0] tgt_row;
    logic [3:0] tgt_col;
    logic       tgt_reject;
    logic [1:0] row_off;
    logic [1:0] col_off;
    logic [3:0] nb_row;
    logic [3:0] nb_col;
    logic       nb_occ;

    assign pick_edge = pick_ship && !pick_prev_q;
    assign tgt_row   = mouse_position[7:4];
    assign tgt_col   = mouse_position[3:0];

    // Target is refused straight from IDLE if off-board, board full, or already taken.
    assign tgt_reject = !in_grid(tgt_row, tgt_col) || (ship_count_q == MAX_CNT) ||
                        cell_at(occ_q, tgt_row, tgt_col);

    // Map the scan index onto a (row, col) offset in the 3x3 window; off-board cells count as free.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
        row_off = 2'd0;
        col_off = 2'd0;
        case (idx_q)
            4'd0: begin row_off = 2'd0; col_off = 2'd0; end
            4'd1: begin row_off = 2'd0; col_off = 2'd1; end
            4'd2: begin row_off = 2'd0; col_off = 2'd2; end
            4'd3: begin row_off = 2'd1; col_off = 2'd0; end
            4'd4: begin row_off = 2'd1; col_off = 2'd1; end
            4'd5: begin row_off = 2'd1; col_off = 2'd2; end
            4'd6: begin row_off = 2'd2; col_off = 2'd0; end
            4'd7: begin row_off = 2'd2; col_off = 2'd1; end
            4'd8: begin row_off = 2'd2; col_off = 2'd2; end
            default: begin row_off = 2'd0; col_off = 2'd0; end
        endcase
        // Row 0 minus one wraps to 15, which in_grid rejects, so edges need no special case.
        nb_row = row_q + {2'b00, row_off} - 4'd1;
        nb_col = col_q + {2'b00, col_off} - 4'd1;
        nb_occ = in_grid(nb_row, nb_col) && cell_at(occ_q, nb_row, nb_col);
    end

    // Placement FSM: edge detect, target check, window scan, commit, result pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            row_q        <= 4'd0;
            col_q        <= 4'd0;
            idx_q        <= 4'd0;
            // Starts high so a button held through reset is not seen as a new press.
            pick_prev_q  <= 1'b1;
            ship_count_q <= 4'd0;
            busy_q       <= 1'b0;
            place_done_q <= 1'b0;
            place_ok_q   <= 1'b0;
            // NOTE: the board is only 100 flops and must read empty straight out of reset, so it is reset like any other register rather than treated as a RAM.
            occ_q        <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples the pre-edge values of the others.
            pick_prev_q  <= pick_ship;
            place_done_q <= 1'b0;
            place_ok_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_edge) begin
                        row_q <= tgt_row;
                        col_q <= tgt_col;
                        idx_q <= 4'd0;
                        if (tgt_reject) begin
                            state_q      <= DONE;
                            place_done_q <= 1'b1;
                        end else begin
                            state_q <= SCAN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (nb_occ) begin
                        state_q      <= DONE;
                        busy_q       <= 1'b0;
                        place_done_q <= 1'b1;
                    end else if (idx_q == IDX_END) begin
                        state_q <= COMMIT;
                    end else begin
                        idx_q <= idx_q + 4'd1;
                    end
                end
                COMMIT: begin
                    occ_q[row_q][col_q] <= 1'b1;
                    if (ship_count_q != MAX_CNT) begin
                        ship_count_q <= ship_count_q + 4'd1;
                    end
                    state_q      <= DONE;
                    busy_q       <= 1'b0;
                    place_done_q <= 1'b1;
                    place_ok_q   <= 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Shot resolution and renderer reads; shots see the pre-edge board, so a same-cycle commit is a miss.
    always_comb begin
        logic [3:0] s_row;
        logic [3:0] s_col;
        logic       s_occ;
        logic       s_was_hit;
        logic [3:0] r_row;
        logic [3:0] r_col;

        hit_d       = hit_q;
        sunk_d      = sunk_q;
        shot_done_d = shot_req;
        shot_hit_d  = 1'b0;

        s_row     = shot_pos[7:4];
        s_col     = shot_pos[3:0];
        s_occ     = in_grid(s_row, s_col) && cell_at(occ_q, s_row, s_col);
        s_was_hit = cell_at(hit_q, s_row, s_col);

        if (shot_req) begin
            shot_hit_d = s_occ;
            if (s_occ && !s_was_hit) begin
                hit_d[s_row][s_col] = 1'b1;
                if (sunk_q != MAX_CNT) begin
                    sunk_d = sunk_q + 4'd1;
                end
            end
        end

        r_row    = rd_pos[7:4];
        r_col    = rd_pos[3:0];
        rd_occ_d = in_grid(r_row, r_col) && cell_at(occ_q, r_row, r_col);
        rd_hit_d = in_grid(r_row, r_col) && cell_at(hit_q, r_row, r_col);
    end

    // Shot and read registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_q       <= '0;
            sunk_q      <= 4'd0;
            shot_done_q <= 1'b0;
            shot_hit_q  <= 1'b0;
            rd_occ_q    <= 1'b0;
            rd_hit_q    <= 1'b0;
        end else begin
            hit_q       <= hit_d;
            sunk_q      <= sunk_d;
            shot_done_q <= shot_done_d;
            shot_hit_q  <= shot_hit_d;
            rd_occ_q    <= rd_occ_d;
            rd_hit_q    <= rd_hit_d;
        end
    end

    assign ship_count = ship_count_q;
    assign place_done = place_done_q;
    assign place_ok   = place_ok_q;
    assign busy       = busy_q;
    assign shot_done  = shot_done_q;
    assign shot_hit   = shot_hit_q;
    assign rd_occ     = rd_occ_q;
    assign rd_hit     = rd_hit_q;
    assign all_sunk   = (sunk_q == ship_count_q) && (ship_count_q == MAX_CNT);

endmodule
